// File: rtl/microstep_phase.sv
// microstep_phase
//   Microstepping phase accumulator and two-coil magnitude sequencer.
//   Each accepted step moves the electrical phase (256 = one cycle) and
//   launches a LUT sequence that reads a shared quarter-wave cosine table
//   for coil A (phase) and coil B (phase - 64). The results are then scaled
//   by the current setting.
//
//   Ports
//     clk          in   clock, rising edge
//     reset        in   asynchronous, active-high
//     enable       in   step qualifier
//     step         in   one-cycle step strobe
//     dir          in   1 = add the increment, 0 = subtract it
//     step_shift   in   [2:0] increment = 1 << step_shift (7 behaves as 6)
//     current      in   [7:0] amplitude scale, sampled on the SCALE exit edge
//     cos_index    out  [5:0] address to the external LUT (1-cycle read)
//     cos_value    in   [7:0] LUT data for the previous cycle's address
//     phase        out  [7:0] electrical phase
//     coil_a_mag   out  [7:0] scaled coil A magnitude
//     coil_b_mag   out  [7:0] scaled coil B magnitude
//     coil_a_neg   out  1 = coil A current negative
//     coil_b_neg   out  1 = coil B current negative
//     out_valid    out  one-cycle pulse when the coil outputs update
//     busy         out  high whenever the sequencer is not idle
//     dbg_state    out  [2:0] sequencer state, for observation only
//
//   Handshake: there is no back-pressure. step is accepted on any rising
//   edge where step & enable is high. out_valid is a one-cycle pulse and
//   the coil outputs hold their values until the next pulse.
module microstep_phase #(
   parameter logic [7:0] PHASE_INIT = 8'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       step,
   input  logic       dir,
   input  logic [2:0] step_shift,
   input  logic [7:0] current,
   output logic [5:0] cos_index,
   input  logic [7:0] cos_value,
   output logic [7:0] phase,
   output logic [7:0] coil_a_mag,
   output logic [7:0] coil_b_mag,
   output logic       coil_a_neg,
   output logic       coil_b_neg,
   output logic       out_valid,
   output logic       busy,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ_A = 3'd1,
      S_REQ_B = 3'd2,
      S_CAP_B = 3'd3,
      S_SCALE = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [7:0]  r_phase;
   logic [7:0]  r_lat_phase;
   logic        r_pending;
   logic [7:0]  r_raw_a;
   logic [7:0]  r_raw_b;
   logic [7:0]  r_a_mag;
   logic [7:0]  r_b_mag;
   logic        r_a_neg;
   logic        r_b_neg;
   logic        r_valid;

   logic        w_accept;
   logic [2:0]  w_shift;
   logic [7:0]  w_inc;
   logic [7:0]  w_phase_next;
   logic        w_enter_a;
   logic [7:0]  w_b_phase;
   logic [5:0]  w_idx_a;
   logic [5:0]  w_idx_b;
   logic [15:0] w_prod_a;
   logic [15:0] w_prod_b;

   assign w_accept     = step & enable;
   assign w_shift      = (step_shift == 3'd7) ? 3'd6 : step_shift;
   assign w_inc        = 8'd1 << w_shift;
   // 8-bit arithmetic gives the modulo-256 wrap in both directions.
   assign w_phase_next = !w_accept ? r_phase :
                         (dir ? r_phase + w_inc : r_phase - w_inc);

   // A sequence starts from IDLE on a step, or chains out of SCALE when a
   // step arrived during the sequence (including one arriving in SCALE).
   assign w_enter_a = ((r_state == S_IDLE)  && w_accept) ||
                      ((r_state == S_SCALE) && (r_pending || w_accept));

   // Odd quadrants read the quarter-wave table mirrored.
   assign w_b_phase = r_lat_phase - 8'd64;
   assign w_idx_a   = r_lat_phase[6] ? (6'd63 - r_lat_phase[5:0]) : r_lat_phase[5:0];
   assign w_idx_b   = w_b_phase[6]   ? (6'd63 - w_b_phase[5:0])   : w_b_phase[5:0];

   assign w_prod_a = {8'd0, r_raw_a} * {8'd0, current};
   assign w_prod_b = {8'd0, r_raw_b} * {8'd0, current};

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_next = S_REQ_A;
         S_REQ_A: w_state_next = S_REQ_B;
         S_REQ_B: w_state_next = S_CAP_B;
         S_CAP_B: w_state_next = S_SCALE;
         S_SCALE: w_state_next = w_enter_a ? S_REQ_A : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // Reset parks in REQ_A so one sequence runs after release.
         r_state     <= S_REQ_A;
         r_phase     <= PHASE_INIT;
         r_lat_phase <= PHASE_INIT;
         r_pending   <= 1'b0;
         r_raw_a     <= 8'd0;
         r_raw_b     <= 8'd0;
         r_a_mag     <= 8'd0;
         r_b_mag     <= 8'd0;
         r_a_neg     <= 1'b0;
         r_b_neg     <= 1'b0;
         r_valid     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_phase <= w_phase_next;
         r_valid <= 1'b0;

         // The sequence works on a snapshot so later steps only affect the
         // chained sequence, never the one in flight.
         if (w_enter_a) begin
            r_lat_phase <= w_phase_next;
            r_pending   <= 1'b0;
         end else if (w_accept && (r_state != S_IDLE)) begin
            r_pending   <= 1'b1;
         end

         if (r_state == S_REQ_B) r_raw_a <= cos_value;
         if (r_state == S_CAP_B) r_raw_b <= cos_value;

         if (r_state == S_SCALE) begin
            r_a_mag <= w_prod_a[15:8];
            r_b_mag <= w_prod_b[15:8];
            r_a_neg <= r_lat_phase[7] ^ r_lat_phase[6];
            r_b_neg <= w_b_phase[7] ^ w_b_phase[6];
            r_valid <= 1'b1;
         end
      end
   end

   assign cos_index  = (r_state == S_REQ_B) ? w_idx_b : w_idx_a;
   assign phase      = r_phase;
   assign coil_a_mag = r_a_mag;
   assign coil_b_mag = r_b_mag;
   assign coil_a_neg = r_a_neg;
   assign coil_b_neg = r_b_neg;
   assign out_valid  = r_valid;
   assign busy       = (r_state != S_IDLE);
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_microstep_phase.sv
// tb_microstep_phase
//   Directed bench for microstep_phase. A quarter-wave cosine LUT model
//   (round(255*cos(i*pi/128)), registered read) feeds the DUT. A reference
//   model tracks phase, sequence timing and the queue of phases whose coil
//   results are due. A negedge compare process checks every output on every
//   cycle. Literal checks pin the model at the known vectors.
module tb_microstep_phase;

   localparam logic [7:0] PH_INIT = 8'd0;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       step;
   logic       dir;
   logic [2:0] step_shift;
   logic [7:0] current;
   logic [5:0] cos_index;
   logic [7:0] cos_value;
   logic [7:0] phase;
   logic [7:0] coil_a_mag;
   logic [7:0] coil_b_mag;
   logic       coil_a_neg;
   logic       coil_b_neg;
   logic       out_valid;
   logic       busy;
   logic [2:0] dbg_state;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 0;

   microstep_phase #(.PHASE_INIT(PH_INIT)) dut (
      .clk(clk), .reset(reset), .enable(enable), .step(step), .dir(dir),
      .step_shift(step_shift), .current(current), .cos_index(cos_index),
      .cos_value(cos_value), .phase(phase), .coil_a_mag(coil_a_mag),
      .coil_b_mag(coil_b_mag), .coil_a_neg(coil_a_neg),
      .coil_b_neg(coil_b_neg), .out_valid(out_valid), .busy(busy),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- LUT model ----------------
   int lut [64];
   initial begin
      for (int i = 0; i < 64; i++)
         lut[i] = $rtoi(255.0 * $cos(i * 3.14159265358979 / 128.0) + 0.5);
   end
   always @(posedge clk) cos_value <= lut[cos_index][7:0];

   // ---------------- reference model ----------------
   int         m_phase;
   int         m_cnt;      // edges left until the result edge, 0 = idle
   bit         m_pend;
   bit         m_valid;
   logic [7:0] exp_q[$];   // phases whose results are still owed

   function automatic int exp_mag(input int p, input int cur);
      int o, idx;
      o   = p % 64;
      idx = ((p / 64) % 2 == 1) ? 63 - o : o;
      return (lut[idx] * cur) / 256;
   endfunction

   function automatic bit exp_neg(input int p);
      return (p / 64 == 1) || (p / 64 == 2);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase = PH_INIT;
         m_cnt   = 4;
         m_pend  = 0;
         m_valid = 0;
         exp_q.delete();
         exp_q.push_back(PH_INIT);
      end else begin
         bit acc;
         int inc;
         acc = step & enable;
         inc = 1 << ((step_shift == 3'd7) ? 6 : int'(step_shift));
         if (acc) m_phase = dir ? (m_phase + inc) % 256 : (m_phase + 256 - inc) % 256;
         m_valid = 0;
         if (m_cnt == 1) begin
            m_valid = 1;
            if (m_pend || acc) begin
               m_cnt = 4; m_pend = 0; exp_q.push_back(m_phase[7:0]);
            end else m_cnt = 0;
         end else if (m_cnt > 1) begin
            if (acc) m_pend = 1;
            m_cnt = m_cnt - 1;
         end else if (acc) begin
            m_cnt = 4; m_pend = 0; exp_q.push_back(m_phase[7:0]);
         end
      end
   end

   // ---------------- scoreboard / compare ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   int h_am = 0, h_bm = 0, h_an = 0, h_bn = 0;

   always @(negedge clk) begin
      if (chk_on) begin
         if (reset) begin
            h_am = 0; h_bm = 0; h_an = 0; h_bn = 0;
         end else if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_valid: got 1 expected 0 (t=%0t)", $time);
            end else begin
               int p;
               p = int'(exp_q.pop_front());
               h_am = exp_mag(p, current);
               h_bm = exp_mag((p + 192) % 256, current);
               h_an = exp_neg(p);
               h_bn = exp_neg((p + 192) % 256);
            end
         end
         chk("out_valid", out_valid, m_valid);
         chk("phase", phase, m_phase);
         chk("busy", busy, m_cnt != 0);
         chk("coil_a_mag", coil_a_mag, h_am);
         chk("coil_b_mag", coil_b_mag, h_bm);
         chk("coil_a_neg", coil_a_neg, h_an);
         chk("coil_b_neg", coil_b_neg, h_bn);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_step(input bit d, input logic [2:0] sh, input bit en);
      @(negedge clk); #1;
      step = 1'b1; enable = en; dir = d; step_shift = sh;
      @(negedge clk); #1;
      step = 1'b0; enable = 1'b1;
   endtask

   // Counts negedges until out_valid; a missing pulse is a failed check.
   task automatic wait_valid(input string name, output int lat);
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (out_valid) begin lat = k; break; end
      end
      if (lat == 0) begin
         n_vec++; n_err++;
         $display("FAIL %s_timeout: got no out_valid expected a pulse", name);
      end
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk); #1; reset = 1'b1;
      repeat (2) @(negedge clk);
      #1; reset = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int lat;
      int pulses;
      reset = 1'b1; enable = 1'b1; step = 1'b0; dir = 1'b1;
      step_shift = 3'd0; current = 8'd255;
      repeat (3) @(negedge clk);
      chk_on = 1;
      @(negedge clk);
      chk("rst_phase", phase, 0);
      chk("rst_a_mag", coil_a_mag, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 1);
      #1; reset = 1'b0;

      // Power-on sequence: phase 0 at full current.
      wait_valid("por", lat);
      chk("por_latency", lat, 4);
      chk("por_a_mag", coil_a_mag, 254);
      chk("por_b_mag", coil_b_mag, 5);
      chk("por_a_neg", coil_a_neg, 0);
      chk("por_b_neg", coil_b_neg, 0);
      wait_idle();

      // +64: quadrant 1 for A, quadrant 0 for B.
      do_step(1'b1, 3'd6, 1'b1);
      chk("p64_phase", phase, 64);
      wait_valid("p64", lat);
      chk("p64_latency", lat, 4);
      chk("p64_a_mag", coil_a_mag, 5);
      chk("p64_a_neg", coil_a_neg, 1);
      chk("p64_b_mag", coil_b_mag, 254);
      chk("p64_b_neg", coil_b_neg, 0);
      wait_idle();

      // Back to 0, then -1 wraps to 255.
      do_step(1'b0, 3'd6, 1'b1);
      wait_valid("p0", lat);
      wait_idle();
      do_step(1'b0, 3'd0, 1'b1);
      chk("p255_phase", phase, 255);
      wait_valid("p255", lat);
      chk("p255_a_mag", coil_a_mag, 254);
      chk("p255_a_neg", coil_a_neg, 0);
      chk("p255_b_mag", coil_b_mag, 5);
      chk("p255_b_neg", coil_b_neg, 1);
      wait_idle();

      // +1 wraps to 0, half current.
      current = 8'd128;
      do_step(1'b1, 3'd0, 1'b1);
      chk("wrap_phase", phase, 0);
      wait_valid("wrap", lat);
      chk("wrap_a_mag", coil_a_mag, 127);
      wait_idle();

      // Three back-to-back steps: one extra sequence only.
      @(negedge clk); #1;
      step = 1'b1; dir = 1'b1; step_shift = 3'd0;
      repeat (3) @(negedge clk);
      #1; step = 1'b0;
      pulses = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      chk("burst_pulses", pulses, 2);
      chk("burst_phase", phase, 3);
      chk("burst_a_mag", coil_a_mag, 127);
      chk("burst_b_mag", coil_b_mag, 12);
      chk("burst_b_neg", coil_b_neg, 0);

      // Disabled step is ignored.
      do_step(1'b1, 3'd0, 1'b0);
      chk("dis_phase", phase, 3);
      chk("dis_busy", busy, 0);

      // Reset to phase 0, then shift 7 acts as 6, and reset lands in REQ_B.
      pulse_reset();
      wait_valid("rst2", lat);
      wait_idle();
      do_step(1'b1, 3'd7, 1'b1);
      chk("sh7_phase", phase, 64);
      @(negedge clk); #1; reset = 1'b1;
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      chk("abort_pulses", pulses, 0);
      chk("abort_a_mag", coil_a_mag, 0);
      chk("abort_phase", phase, 0);
      #1; reset = 1'b0;
      wait_valid("restart", lat);
      chk("restart_latency", lat, 4);
      chk("restart_a_mag", coil_a_mag, 127);
      chk("restart_b_mag", coil_b_mag, 3);
      wait_idle();
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/microstep_phase.md
MICROSTEP_PHASE -- requirements
Module: microstep_phase

Interface
REQ-001 The block SHALL have parameter PHASE_INIT, default 8'd0, giving the electrical phase loaded on reset.
REQ-002 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port enable, input, 1: when 0, step is ignored.
REQ-005 Port step, input, 1: single-cycle step strobe, sampled on clk.
REQ-006 Port dir, input, 1: 1 adds the increment to phase, 0 subtracts it.
REQ-007 Port step_shift, input, 3: phase increment = 1<<step_shift; values 7 SHALL be treated as 6.
REQ-008 Port current, input, 8: amplitude scale, sampled in SCALE.
REQ-009 Port cos_index, output, 6: index to the external quarter-wave cosine LUT (64 entries, 1-cycle registered read).
REQ-010 Port cos_value, input, 8: LUT result for the index presented one cycle earlier.
REQ-011 Port phase, output, 8: current electrical phase (256 = one electrical cycle).
REQ-012 Ports coil_a_mag, coil_b_mag, output, 8 each: scaled coil magnitudes.
REQ-013 Ports coil_a_neg, coil_b_neg, output, 1 each: 1 = negative coil current.
REQ-014 Port out_valid, output, 1: one-cycle pulse when coil outputs update.
REQ-015 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-016 On an accepted step (step & enable), phase SHALL update at that same edge, modulo 256 (wraps both ways).
REQ-017 Coil A phase = phase; coil B phase = phase - 64 (mod 256); quadrant q = p[7:6], offset o = p[5:0].
REQ-018 LUT index = o for q in {0,2}, 63-o for q in {1,3}; neg = 1 for q in {1,2}, else 0.
REQ-019 FSM states: IDLE, REQ_A, REQ_B, CAP_B, SCALE.
REQ-020 IDLE -> REQ_A on an accepted step; REQ_A -> REQ_B -> CAP_B -> SCALE unconditionally.
REQ-021 SCALE -> REQ_A if a step was accepted during REQ_A..SCALE (pending flag); otherwise SCALE -> IDLE; the pending flag clears on entry to REQ_A.
REQ-022 cos_index SHALL be combinational: index A in REQ_A, index B in REQ_B, otherwise index A.
REQ-023 Raw A SHALL be captured from cos_value at the REQ_B->CAP_B edge and raw B at the CAP_B->SCALE edge.
REQ-024 Polarity bits SHALL be computed from the phase latched on entry to REQ_A, so steps accepted mid-sequence do not corrupt the current result.
REQ-025 At the SCALE exit edge: mag = (raw * current)[15:8] (16-bit unsigned product, truncated); neg bits are updated; out_valid pulses for one cycle.
REQ-026 Latency SHALL be 4 cycles: step accepted at edge N gives out_valid high in the cycle after edge N+4.
REQ-027 Multiple steps accepted during one sequence SHALL all accumulate into phase and trigger exactly one extra sequence.
REQ-028 Coil outputs SHALL hold their values between out_valid pulses.

Reset
REQ-029 While reset is high: phase = PHASE_INIT; coil mags = 0; neg bits = 0; out_valid = 0; pending = 0; state = REQ_A.
REQ-030 After reset release, one sequence SHALL run automatically so the outputs reflect PHASE_INIT.
REQ-031 Reset asserted mid-sequence SHALL abort the sequence with no out_valid pulse; the sequence restarts after release.

Verification
REQ-032 Reset release, current=255, PHASE_INIT=0 -> out_valid after 4 cycles; A mag 254, neg 0; B (index 63, value 6) mag 5, neg 0.
REQ-033 From phase 0: step with dir=1, step_shift=6 -> phase 64; A mag 5, neg 1; B mag 254, neg 0; out_valid at N+4.
REQ-034 From phase 0: step with dir=0, step_shift=0 -> phase 255; A mag 254, neg 0; B mag 5, neg 1.
REQ-035 Phase 255: step with dir=1, step_shift=0 -> phase 0 (wrap); current=128 -> A mag 127.
REQ-036 Three steps (shift 0, dir 1) while busy -> phase +3; exactly two out_valid pulses; final outputs match phase 3; step with enable=0 leaves phase unchanged.
REQ-037 step_shift=7, dir=1 from phase 0 -> phase 64; reset asserted in REQ_B -> no out_valid, outputs 0.
